apb_master: RTL

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 7 +
 rtl/apb_master.sv | 78 +++++++
 2 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: APB FSM state encoding and default bus widths.
// Shared by the APB requester and the APB completer.
package apb_pkg;
    localparam int APB_ADDR_W = 4;
    localparam int APB_DATA_W = 8;
    typedef enum logic [1:0] {IDLE = 2'b00, SETUP = 2'b01, ACCESS = 2'b10} apb_state_e;
endpackage

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester with a bounded wait on pready.
// Each command runs one SETUP/ACCESS transfer and returns a one-cycle response pulse.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslverr,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    apb_state_e state, state_nxt;
    logic [7:0] cnt;
    logic       accept, done, tout;

    assign cmd_ready = (state == IDLE);
    assign psel      = (state != IDLE);
    assign penable   = (state == ACCESS);
    assign accept    = cmd_valid && cmd_ready;
    assign done      = (state == ACCESS) && pready;
    // pready wins over the timeout when both land on the same cycle
    assign tout      = (state == ACCESS) && !pready && (cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == IDLE)   ? (cmd_valid ? SETUP : IDLE) :
                    (state == SETUP)  ? ACCESS :
                    (state == ACCESS && !(done || tout)) ? ACCESS : IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            cnt       <= 8'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                pwrite <= cmd_wr;
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
            end
            cnt       <= accept ? 8'd0 : (state == ACCESS) ? cnt + 8'd1 : cnt;
            rsp_valid <= done || tout;
            if (done) begin
                rsp_rdata <= pwrite ? '0 : prdata;
                rsp_err   <= pslverr;
            end else if (tout) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end
endmodule
